// File: rtl/adc7478_pkg.sv
// Shared types and timing constants for the AD7478 serial ADC controller.
package adc7478_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_PWRUP,
    ST_CONV,
    ST_QUIET,
    ST_PDOWN
  } state_t;

  localparam int SCLK_HALF    = 2;
  localparam int FRAME_SCLKS  = 16;
  localparam int DATA_FIRST   = 5;
  localparam int DATA_LAST    = 12;
  localparam int PD_SCLKS     = 4;
  localparam int QUIET_CYCLES = 4;
  localparam int PWRUP_CYCLES = 50;

  localparam int SCLK_CNT_W = $clog2(FRAME_SCLKS + 1);
  localparam int WAIT_CNT_W = $clog2(PWRUP_CYCLES + 1);

  // Samples arrive MSB first: sample 1 lands in the top bit of the frame word.
  function automatic int sample_bit(input int sample_no);
    return FRAME_SCLKS - sample_no;
  endfunction

endpackage

// File: rtl/adc7478_sclk_gen.sv
// SCLK generator: SCLK_HALF cycles high then SCLK_HALF low while enabled, counting completed
// periods; finishes a burst of 'sclks' periods with one extra high phase and reports done.
module adc7478_sclk_gen
  import adc7478_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  en,
  input  logic [SCLK_CNT_W-1:0] sclks,
  output logic                  sclk,
  output logic                  sample,
  output logic                  done,
  output logic [SCLK_CNT_W-1:0] edge_cnt
);

  localparam int PHASE_W = $clog2(2 * SCLK_HALF);

  logic [PHASE_W-1:0]    phase_reg, phase_next;
  logic [SCLK_CNT_W-1:0] cnt_reg, cnt_next;
  logic                  sclk_reg;
  logic                  last_high;

  assign last_high = en && (phase_reg == PHASE_W'(SCLK_HALF - 1));
  assign done      = last_high && (cnt_reg == sclks);
  assign sample    = last_high && (cnt_reg < sclks);
  assign sclk      = sclk_reg;
  assign edge_cnt  = cnt_reg;

  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    if (!en || done) begin
      phase_next = '0;
      cnt_next   = '0;
    end else if (phase_reg == PHASE_W'(2 * SCLK_HALF - 1)) begin
      phase_next = '0;
      cnt_next   = cnt_reg + 1'b1;
    end else begin
      phase_next = phase_reg + 1'b1;
    end
  end

  // sclk is registered from the next phase so the pin never glitches.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      phase_reg <= '0;
      cnt_reg   <= '0;
      sclk_reg  <= 1'b1;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      sclk_reg  <= (phase_next < PHASE_W'(SCLK_HALF));
    end
  end

endmodule

// File: rtl/adc7478_ctrl.sv
// AD7478 serial master: frames CS, runs SCLK at clk_in/4, returns the 8 data bits with an eoc pulse.
// Optional ADC7478_ZERO_CHECK_EN adds frame_err, flagging a 1 in any leading/trailing zero sample.
module adc7478_ctrl
  import adc7478_pkg::*;
#(
  parameter logic DEFAULT_STATE               = 1'b0,
  parameter logic POWER_DOWN_AFTER_CONVERTING = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  output logic       cs,
  output logic       clk,
  input  logic       so,
  output logic       eoc,
  output logic [7:0] data
`ifdef ADC7478_ZERO_CHECK_EN
  ,
  output logic       frame_err
`endif
);

  localparam int DATA_MSB = sample_bit(DATA_FIRST);
  localparam int DATA_LSB = sample_bit(DATA_LAST);
`ifdef ADC7478_ZERO_CHECK_EN
  localparam int CAP_HI = FRAME_SCLKS - 1;
  localparam int CAP_LO = 0;
`else
  localparam int CAP_HI = DATA_MSB;
  localparam int CAP_LO = DATA_LSB;
`endif

  state_t                state_reg;
  logic                  cs_reg;
  logic                  eoc_reg;
  logic [7:0]            data_reg;
  logic                  asleep_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic [CAP_HI:CAP_LO]  frame_reg;
  logic [CAP_HI:CAP_LO]  cap_hit;

  logic                  sclk_en;
  logic [SCLK_CNT_W-1:0] sclks;
  logic                  sample;
  logic                  done;
  logic [SCLK_CNT_W-1:0] edge_cnt;

  assign sclk_en = (state_reg == ST_CONV) || (state_reg == ST_WAKE) || (state_reg == ST_PDOWN);
  assign sclks   = (state_reg == ST_PDOWN) ? SCLK_CNT_W'(PD_SCLKS) : SCLK_CNT_W'(FRAME_SCLKS);

  adc7478_sclk_gen u_sclk_gen (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (sclk_en),
    .sclks    (sclks),
    .sclk     (clk),
    .sample   (sample),
    .done     (done),
    .edge_cnt (edge_cnt)
  );

  // Each kept frame bit captures so on the sample strobe of its own SCLK period.
  genvar gi;
  generate
    for (gi = CAP_LO; gi <= CAP_HI; gi++) begin : g_cap
      assign cap_hit[gi] = sample && (edge_cnt == SCLK_CNT_W'(FRAME_SCLKS - 1 - gi));
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      frame_reg <= '0;
    end else begin
      for (int i = CAP_LO; i <= CAP_HI; i++) begin
        if (cap_hit[i]) frame_reg[i] <= so;
      end
    end
  end

`ifdef ADC7478_ZERO_CHECK_EN
  logic err_reg;
  assign frame_err = err_reg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_CONV && done) begin
      err_reg <= (|frame_reg[FRAME_SCLKS-1:DATA_MSB+1]) || (|frame_reg[DATA_LSB-1:0]);
    end
  end
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cs_reg       <= 1'b1;
      eoc_reg      <= 1'b0;
      data_reg     <= '0;
      asleep_reg   <= DEFAULT_STATE;
      wait_cnt_reg <= '0;
    end else begin
      eoc_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cs_reg    <= 1'b0;
            state_reg <= asleep_reg ? ST_WAKE : ST_CONV;
          end
        end
        // Dummy frame only wakes the ADC; its result is dropped.
        ST_WAKE: begin
          if (done) begin
            cs_reg       <= 1'b1;
            asleep_reg   <= 1'b0;
            wait_cnt_reg <= '0;
            state_reg    <= ST_PWRUP;
          end
        end
        ST_PWRUP: begin
          if (wait_cnt_reg == WAIT_CNT_W'(PWRUP_CYCLES - 1)) begin
            cs_reg    <= 1'b0;
            state_reg <= ST_CONV;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_CONV: begin
          if (done) begin
            cs_reg       <= 1'b1;
            eoc_reg      <= 1'b1;
            data_reg     <= frame_reg[DATA_MSB:DATA_LSB];
            wait_cnt_reg <= '0;
            state_reg    <= ST_QUIET;
          end
        end
        // Quiet also follows a power-down frame; the asleep flag keeps it from looping.
        ST_QUIET: begin
          if (wait_cnt_reg == WAIT_CNT_W'(QUIET_CYCLES - 1)) begin
            if (POWER_DOWN_AFTER_CONVERTING && !asleep_reg) begin
              cs_reg    <= 1'b0;
              state_reg <= ST_PDOWN;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_PDOWN: begin
          if (done) begin
            cs_reg       <= 1'b1;
            asleep_reg   <= 1'b1;
            wait_cnt_reg <= '0;
            state_reg    <= ST_QUIET;
          end
        end
        default: begin
          cs_reg    <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cs   = cs_reg;
  assign eoc  = eoc_reg;
  assign data = data_reg;

endmodule

// File: tb/tb_adc7478_ctrl.sv
// Scoreboard bench for adc7478_ctrl: default, asleep-at-reset and power-down-after-convert instances.
module tb_adc7478_ctrl;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic       so     = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] cs_v, clk_v, eoc_v;
  logic [7:0] data_v [3];
`ifdef ADC7478_ZERO_CHECK_EN
  logic [2:0] err_v;
`endif

  always #10 clk_in = ~clk_in;

  adc7478_ctrl u_dut (
    .clk_in (clk_in), .rst (rst), .start (start_v[0]), .cs (cs_v[0]), .clk (clk_v[0]),
    .so (so), .eoc (eoc_v[0]), .data (data_v[0])
`ifdef ADC7478_ZERO_CHECK_EN
    , .frame_err (err_v[0])
`endif
  );

  adc7478_ctrl #(.DEFAULT_STATE(1'b1)) u_sleep (
    .clk_in (clk_in), .rst (rst), .start (start_v[1]), .cs (cs_v[1]), .clk (clk_v[1]),
    .so (so), .eoc (eoc_v[1]), .data (data_v[1])
`ifdef ADC7478_ZERO_CHECK_EN
    , .frame_err (err_v[1])
`endif
  );

  adc7478_ctrl #(.POWER_DOWN_AFTER_CONVERTING(1'b1)) u_pd (
    .clk_in (clk_in), .rst (rst), .start (start_v[2]), .cs (cs_v[2]), .clk (clk_v[2]),
    .so (so), .eoc (eoc_v[2]), .data (data_v[2])
`ifdef ADC7478_ZERO_CHECK_EN
    , .frame_err (err_v[2])
`endif
  );

  // Only the selected instance talks to the ADC model and the monitor.
  int         sel = 0;
  logic       adc_cs, adc_clk, adc_eoc;
  logic [7:0] adc_data;
  assign adc_cs   = cs_v[sel];
  assign adc_clk  = clk_v[sel];
  assign adc_eoc  = eoc_v[sel];
  assign adc_data = data_v[sel];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: first bit on CS fall, next bit after each SCLK fall.
  logic [15:0] word = '0;
  int          bit_idx = 0;
  always @(negedge adc_cs or negedge adc_clk) begin
    if (adc_clk) begin
      so      = word[15];
      bit_idx = 14;
    end else if (!adc_cs && bit_idx >= 0) begin
      so = word[bit_idx];
      bit_idx--;
    end
  end

  logic [8:0] exp_q [$];   // {frame_err, data} per expected eoc
  int         len_q [$];   // expected CS-low length per frame

  int         len = 0, falls = 0, eoc_cnt = 0, exp_len = 0;
  logic [8:0] exp_item;
  logic       prev_cs = 1'b1, prev_clk = 1'b1;

  always @(negedge clk_in) begin
    if (rst) begin
      len   = 0;
      falls = 0;
    end else begin
      if (adc_eoc) begin
        eoc_cnt++;
        check_value("eoc_align", {30'd0, prev_cs, adc_cs}, 32'd1);
        if (exp_q.size() == 0) begin
          check_value("stray_eoc", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_item = exp_q.pop_front();
          $display("txn dut=%0d data=0x%02h exp=0x%02h", sel, adc_data, exp_item[7:0]);
          check_value("data", {24'd0, adc_data}, {24'd0, exp_item[7:0]});
`ifdef ADC7478_ZERO_CHECK_EN
          check_value("frame_err", {31'd0, err_v[sel]}, {31'd0, exp_item[8]});
`endif
        end
      end
      if (!adc_cs) begin
        len++;
        if (prev_clk && !adc_clk) falls++;
      end else if (len != 0) begin
        if (len_q.size() == 0) begin
          check_value("stray_frame", 32'(len_q.size()), 32'd1);
        end else begin
          exp_len = len_q.pop_front();
          check_value("frame_len", len, exp_len);
          check_value("sclk_falls", falls, (exp_len == 18) ? 4 : 16);
          check_value("clk_idle", {31'd0, adc_clk}, 32'd1);
        end
        len   = 0;
        falls = 0;
      end
    end
    prev_cs  = adc_cs;
    prev_clk = adc_clk;
  end

  task automatic pulse(input int idx);
    @(negedge clk_in);
    start_v[idx] = 1'b1;
    @(negedge clk_in);
    start_v[idx] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || len_q.size() != 0) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check_value("drain", 32'(exp_q.size() + len_q.size()), 32'd0);
    repeat (12) @(negedge clk_in);
  endtask

  task automatic wait_cs(input int idx, input logic lvl, input int budget);
    int n = 0;
    while (cs_v[idx] !== lvl && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check_value("wait_cs", {31'd0, cs_v[idx]}, {31'd0, lvl});
  endtask

  task automatic high_len(input int idx, output int n);
    n = 0;
    while (cs_v[idx] === 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
  endtask

  logic [15:0] err_words [3] = '{16'h4A50, 16'h0A51, 16'h0A50};
  logic        err_exp   [3] = '{1'b1, 1'b1, 1'b0};
  int          gap, eoc_before;

  initial begin
    repeat (3) @(negedge clk_in);
    check_value("rst_cs",   {31'd0, cs_v[0]},  32'd1);
    check_value("rst_clk",  {31'd0, clk_v[0]}, 32'd1);
    check_value("rst_eoc",  {31'd0, eoc_v[0]}, 32'd0);
    check_value("rst_data", {24'd0, data_v[0]}, 32'd0);
    rst = 1'b0;

    // Held start: three back-to-back frames in 200 cycles.
    sel  = 0;
    word = 16'h0000;
    repeat (3) begin
      exp_q.push_back(9'h000);
      len_q.push_back(66);
    end
    @(negedge clk_in);
    start_v[0] = 1'b1;
    repeat (200) @(negedge clk_in);
    start_v[0] = 1'b0;
    drain(400);
    check_value("held_start_eocs", eoc_cnt, 3);

    word = 16'h0A50;
    exp_q.push_back(9'h0A5);
    len_q.push_back(66);
    pulse(0);
    drain(200);
    check_value("data_hold", {24'd0, data_v[0]}, 32'hA5);

    // Asleep at reset: dummy wake frame, 50-cycle power-up gap, then the real frame.
    sel  = 1;
    word = 16'h0330;
    exp_q.push_back(9'h033);
    len_q.push_back(66);
    len_q.push_back(66);
    pulse(1);
    wait_cs(1, 1'b0, 10);
    wait_cs(1, 1'b1, 100);
    high_len(1, gap);
    check_value("pwrup_gap", gap, 50);
    drain(300);

    // Power-down after converting, then the next start must wake first.
    sel  = 2;
    word = 16'h0C30;
    exp_q.push_back(9'h0C3);
    len_q.push_back(66);
    len_q.push_back(18);
    pulse(2);
    wait_cs(2, 1'b0, 10);
    wait_cs(2, 1'b1, 100);
    high_len(2, gap);
    check_value("quiet_gap", gap, 4);
    drain(200);
    word = 16'h07F0;
    exp_q.push_back(9'h07F);
    len_q.push_back(66);
    len_q.push_back(66);
    len_q.push_back(18);
    pulse(2);
    drain(400);

    // Leading/trailing zero violations.
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      word = err_words[i];
      exp_q.push_back({err_exp[i], 8'hA5});
      len_q.push_back(66);
      pulse(0);
      drain(200);
    end

    // Reset mid-frame.
    word = 16'h0FF0;
    pulse(0);
    repeat (30) @(negedge clk_in);
    #3 rst = 1'b1;
    #1;
    check_value("midrst_cs",   {31'd0, cs_v[0]},  32'd1);
    check_value("midrst_clk",  {31'd0, clk_v[0]}, 32'd1);
    check_value("midrst_eoc",  {31'd0, eoc_v[0]}, 32'd0);
    check_value("midrst_data", {24'd0, data_v[0]}, 32'd0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    eoc_before = eoc_cnt;
    repeat (150) @(negedge clk_in);
    check_value("no_stray_eoc", eoc_cnt, eoc_before);
    check_value("idle_cs", {31'd0, cs_v[0]}, 32'd1);

    check_value("queues_empty", 32'(exp_q.size() + len_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
